// File: rtl/decode_sched_pkg.sv
// Shared constants and state encoding for the round-robin decode scheduler.
package decode_sched_pkg;
    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;
endpackage

// File: rtl/decode_sched_sel_decoder.sv
// One-hot grant decode: out has a single bit at select while valid, else zero.
module sel_decoder
    import decode_sched_pkg::*;
#(
    parameter int NUM_REQ = decode_sched_pkg::NUM_REQ
) (
    input  logic [SEL_W-1:0]   select,
    input  logic               valid,
    output logic [NUM_REQ-1:0] out
);
    always_comb begin
        out = '0;
        if (valid) out[select] = 1'b1;
    end
endmodule

// File: rtl/decode_sched.sv
// Round-robin grant scheduler: arbitrate, hold a grant until done or hold
// timeout, then release for one cycle and rotate priority past the last grantee.
module decode_sched
    import decode_sched_pkg::*;
#(
    parameter int NUM_REQ  = decode_sched_pkg::NUM_REQ,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   select,
    output logic [NUM_REQ-1:0] out,
    output logic               valid,
    output logic               busy,
    output logic               timeout
);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    state_t            state;
    logic [SEL_W-1:0]  ptr;
    logic [HOLD_W-1:0] cnt;
    logic [SEL_W-1:0]  pick;
    logic [SEL_W-1:0]  idx;
    logic              found;

    // Search starts just past the last grantee; ptr itself is visited last.
    always_comb begin
        found = 1'b0;
        pick  = select;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            select  <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            cnt     <= '0;
            ptr     <= SEL_W'(NUM_REQ - 1);
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && |req) begin
                        state <= ARB;
                        busy  <= 1'b1;
                    end
                end
                ARB: begin
                    if (found) begin
                        select <= pick;
                        valid  <= 1'b1;
                        cnt    <= '0;
                        state  <= GRANT;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    // done takes precedence, so a simultaneous expiry is not a timeout
                    if (done || cnt == HOLD_W'(MAX_HOLD - 1)) begin
                        timeout <= !done;
                        valid   <= 1'b0;
                        ptr     <= select;
                        cnt     <= '0;
                        state   <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (start && |req) begin
                        state <= ARB;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // out decodes from async-reset registers, so reset clears it without a clock
    sel_decoder #(.NUM_REQ(NUM_REQ)) u_dec (
        .select (select),
        .valid  (valid),
        .out    (out)
    );
endmodule

// File: tb/tb_decode_sched.sv
// Bench for decode_sched: vector table, directed corner sequences and random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_decode_sched;
    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [2:0] select;
    logic [7:0] out;
    logic       valid, busy, timeout;

    int n_pass = 0;
    int n_tot  = 0;

    decode_sched #(.NUM_REQ(8), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .req     (req),
        .done    (done),
        .select  (select),
        .out     (out),
        .valid   (valid),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: a live grant, a pending arbitration, or a one-cycle gap.
    bit m_live, m_arb_pend, m_gap, m_to;
    int m_sel, m_last, m_age;

    function automatic void model_reset();
        m_live = 0; m_arb_pend = 0; m_gap = 0; m_to = 0;
        m_sel = 0; m_last = 7; m_age = 0;
    endfunction

    function automatic void model_edge(bit s, logic [7:0] r, bit d);
        int nxt;
        m_to = 0;
        if (m_live) begin
            if (d || m_age == MAX_HOLD - 1) begin
                m_live = 0; m_last = m_sel; m_to = !d; m_gap = 1;
            end else m_age++;
        end else if (m_arb_pend) begin
            m_arb_pend = 0;
            nxt = -1;
            for (int k = 1; k <= 8; k++)
                if (nxt < 0 && r[(m_last + k) % 8]) nxt = (m_last + k) % 8;
            if (nxt >= 0) begin m_sel = nxt; m_live = 1; m_age = 0; end
        end else begin
            m_gap = 0;
            m_arb_pend = s && (r != 0);
        end
    endfunction

    function automatic logic [13:0] pack(int sel, bit v, bit b, bit t);
        logic [7:0] oh;
        oh = v ? 8'(1 << sel) : 8'h00;
        return {3'(sel), oh, v, b, t};
    endfunction

    function automatic logic [13:0] model_exp();
        return pack(m_sel, m_live, m_live || m_arb_pend || m_gap, m_to);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Advance one edge; the model sees the same inputs the DUT sampled.
    task automatic step();
        @(posedge clk);
        model_edge(start, req, done);
        #1;
        chk("cyc", {select, out, valid, busy, timeout}, model_exp());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0; start = 0; req = 8'h00; done = 0;
        #1;
        model_reset();
        chk("reset", {select, out, valid, busy, timeout}, pack(0, 0, 0, 0));
        #1 rst = 1;
    endtask

    task automatic wait_valid(string name);
        bit ok = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (valid) begin ok = 1; break; end
        end
        chk({name, "_wait"}, 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic       s;
        logic [7:0] r;
        logic       d;
        int         sel;
        logic       v, b, t;
    } vec_t;

    vec_t tbl[10];
    int   grants[$];
    int   nv;

    initial begin
        // Single requester: grant two edges after start, done on 3rd GRANT cycle, regrant.
        tbl[0] = '{1'b1, 8'h01, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'h01, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'h01, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 8'h01, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 8'h01, 1'b1, 0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 8'h01, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 8'h01, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {select, out, valid, busy, timeout}, pack(0, 0, 0, 0));
        @(negedge clk) rst = 1;

        for (int i = 0; i < 10; i++) begin
            start = tbl[i].s; req = tbl[i].r; done = tbl[i].d;
            step();
            chk("tbl", {select, out, valid, busy, timeout},
                pack(tbl[i].sel, tbl[i].v, tbl[i].b, tbl[i].t));
        end

        // All requesting, done every grant: rotation 0..7,0.
        do_reset();
        start = 1; req = 8'hFF; done = 1;
        grants.delete();
        for (int i = 0; i < 40 && grants.size() < 9; i++) begin
            step();
            if (valid) grants.push_back(int'(select));
        end
        chk("rot_cnt", 32'(grants.size()), 32'd9);
        foreach (grants[k]) chk("rot_sel", 32'(grants[k]), 32'(k % 8));

        // Hold timeout after 16 GRANT cycles, then regrant 4; then done on the last cycle wins.
        do_reset();
        start = 1; req = 8'h10; done = 0;
        wait_valid("to");
        nv = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!valid) break;
            nv++;
        end
        chk("to_len", 32'(nv), 32'(MAX_HOLD));
        chk("to_pulse", {24'h0, out, timeout}, {24'h0, 8'h00, 1'b1});
        step();
        step();
        chk("to_regrant", {29'h0, select}, 32'd4);
        chk("to_regrant_v", 32'(valid), 32'd1);
        repeat (MAX_HOLD - 1) step();
        done = 1;
        step();
        chk("collide", {30'h0, valid, timeout}, 32'd0);
        done = 0;

        // Priority wraps: ptr=2 with req 0x24 gives 5 then 2.
        do_reset();
        start = 1; req = 8'h04; done = 1;
        wait_valid("wrap0");
        chk("wrap0", {29'h0, select}, 32'd2);
        req = 8'h24;
        wait_valid("wrap1");
        chk("wrap1", {29'h0, select}, 32'd5);
        wait_valid("wrap2");
        chk("wrap2", {29'h0, select}, 32'd2);

        // Asynchronous reset mid-grant clears outputs without a clock edge.
        do_reset();
        start = 1; req = 8'h08; done = 0;
        wait_valid("arst");
        chk("arst_pre", {24'h0, out}, 32'h08);
        #2 rst = 0;
        #1;
        chk("arst", {29'h0, out != 8'h00, valid, busy}, 32'd0);
        model_reset();
        #1 rst = 1;
        req = 8'h0A;
        wait_valid("arst_post");
        chk("arst_post", {29'h0, select}, 32'd1);

        // start dropped during GRANT: grant completes, then RELEASE -> IDLE.
        do_reset();
        start = 1; req = 8'hFF; done = 0;
        wait_valid("stop");
        start = 0;
        step();
        chk("stop_hold", {30'h0, valid, busy}, 32'd3);
        done = 1;
        step();
        chk("stop_rel", {30'h0, valid, busy}, 32'd1);
        done = 0;
        step();
        chk("stop_idle", {30'h0, valid, busy}, 32'd0);
        step();
        chk("stop_stay", {30'h0, valid, busy}, 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            start = ($urandom % 8) != 0;
            case ($urandom % 4)
                0: req = 8'h00;
                1: req = 8'(1 << ($urandom % 8));
                default: req = 8'($urandom);
            endcase
            done = ($urandom % 6) == 0;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_tot);
        $fatal(1, "watchdog");
    end
endmodule
